// File: rtl/fb_access_arbiter.sv
// fb_access_arbiter: two-port round-robin arbiter for the framebuffer random-access port (optional abort via FB_ARBITER_TIMEOUT_EN)
module fb_access_arbiter #(
    parameter int ADDR_W         = 24,
    parameter int DATA_W         = 16,
    parameter int MASK_W         = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                   clk,
    input  logic                   reset_i,
    input  logic [1:0]             sel_i,
    input  logic [1:0]             wr_i,
    input  logic [1:0][MASK_W-1:0] mask_i,
    input  logic [1:0][ADDR_W-1:0] address_i,
    input  logic [1:0][DATA_W-1:0] data_in_i,
    output logic [1:0]             ack_o,
    output logic [1:0][DATA_W-1:0] data_out_o,
    output logic                   fb_sel_o,
    output logic                   fb_wr_o,
    output logic [MASK_W-1:0]      fb_mask_o,
    output logic [ADDR_W-1:0]      fb_address_o,
    output logic [DATA_W-1:0]      fb_data_o,
    input  logic                   fb_ack_i,
    input  logic [DATA_W-1:0]      fb_data_i,
    output logic [1:0]             grant_o,
    output logic                   timeout_o
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t r_state, w_next;
    logic   r_gnt, r_last, w_win, w_done, w_to;
    assign w_win  = &sel_i ? ~r_last : sel_i[1];
    assign w_done = (r_state == BUSY) && (fb_ack_i || w_to);
`ifdef FB_ARBITER_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] r_cnt;
    logic          r_timeout;
    assign w_to      = ~fb_ack_i && (r_cnt == CW'(TIMEOUT_CYCLES - 1));
    assign timeout_o = r_timeout;
    // count unacknowledged BUSY cycles; a real ack in the limit cycle wins over the abort
    always_ff @(posedge clk) begin
        if (reset_i) begin
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else begin
            if (r_state == IDLE) r_cnt <= '0;
            else if (r_state == BUSY && !fb_ack_i) r_cnt <= r_cnt + 1'b1;
            if (r_state == BUSY && w_to) r_timeout <= 1'b1;
        end
    end
`else
    assign w_to      = 1'b0;
    assign timeout_o = 1'b0;
`endif
    // state register
    always_ff @(posedge clk) begin
        if (reset_i) r_state <= IDLE;
        else r_state <= w_next;
    end
    // next state: DONE is a dead cycle that ignores sel_i
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (|sel_i) w_next = BUSY;
            BUSY:    if (w_done) w_next = DONE;
            default: w_next = IDLE;
        endcase
    end
    // latch the winner's request on issue, route completion back to the owner only
    always_ff @(posedge clk) begin
        if (reset_i) begin
            r_gnt        <= 1'b0;
            r_last       <= 1'b1;
            fb_sel_o     <= 1'b0;
            fb_wr_o      <= 1'b0;
            fb_mask_o    <= '0;
            fb_address_o <= '0;
            fb_data_o    <= '0;
            grant_o      <= '0;
            ack_o        <= '0;
            data_out_o   <= '0;
        end else begin
            ack_o <= '0;
            if (r_state == IDLE && |sel_i) begin
                r_gnt        <= w_win;
                fb_sel_o     <= 1'b1;
                grant_o      <= w_win ? 2'b10 : 2'b01;
                fb_wr_o      <= wr_i[w_win];
                fb_mask_o    <= mask_i[w_win];
                fb_address_o <= address_i[w_win];
                fb_data_o    <= data_in_i[w_win];
            end
            if (w_done) begin
                data_out_o[r_gnt] <= fb_ack_i ? fb_data_i : '0;
                ack_o[r_gnt]      <= 1'b1;
                fb_sel_o          <= 1'b0;
                grant_o           <= '0;
                r_last            <= r_gnt;
            end
        end
    end
endmodule
